// File: rtl/brom_stream_loader.sv
// rtl/brom_stream_loader.sv - stream loader writing a 256x8 block RAM with a registered read port
// Optional checksum output enabled by BROM_LOADER_CHECKSUM_EN.
module brom_stream_loader #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      count,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] y
`ifdef BROM_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t           r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_y;
`ifdef BROM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_csum;
`endif

  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

  logic w_hs;
  logic w_we;

  assign w_hs = r_in_ready & in_valid;
  // A restart pulse wins over a same-cycle handshake, so that word is dropped.
  assign w_we = w_hs & ~start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef BROM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef BROM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (start) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
`ifdef BROM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
          end else if (w_hs) begin
            r_count <= r_count + 1'b1;
`ifdef BROM_LOADER_CHECKSUM_EN
            r_csum  <= r_csum + in_data;
`endif
            // The pointer parks on the top address rather than wrapping.
            if (r_wr_ptr != LAST_ADDR) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (in_last || (r_wr_ptr == LAST_ADDR)) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Read-first: the write above lands after this sample of the old word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_y <= '0;
    end else begin
      r_y <= r_mem[addr];
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign y        = r_y;
`ifdef BROM_LOADER_CHECKSUM_EN
  assign csum     = r_csum;
`endif

endmodule
